turbo_pi_interleaver: RTL and testbench
=======================================

Name: turbo_pi_interleaver

Overview:
- Consumer of the turbo interleaver permutation ROM.
- Buffers one code block of soft values in natural order, then walks the ROM segment for the active link (base..base+len-1) and streams the block out in permuted order: out[k] = in[pi[k]].
- Sits between the LLR/bit source and the turbo encoder/decoder second constituent; one block in flight at a time.

Parameters:
D_WIDTH, 8, soft-value/sample width
PI_WIDTH, 13, permutation index width (matches ROM data)
A_WIDTH, 16, ROM address width
FIFO_DEPTH, 4, output FIFO entries (power of two, >=4)

Ports:
clk  in  1  clock, all logic on rising edge
n_rst  in  1  reset, synchronous, active-low
start  in  1  one-cycle pulse, begin a block (IDLE only)
base_addr  in  A_WIDTH  ROM offset of the link's table, latched on start
blk_len  in  PI_WIDTH  block length 1..8191, latched on start
s_valid  in  1  input sample valid
s_data  in  D_WIDTH  input sample
s_ready  out  1  accepting input (LOAD state)
m_valid  out  1  output sample valid
m_data  out  D_WIDTH  permuted sample
m_last  out  1  marks final sample of block
m_ready  in  1  downstream accept
rom_addr  out  A_WIDTH  permutation ROM address
rom_data  in  PI_WIDTH  ROM data, registered, valid 1 cycle after rom_addr
busy  out  1  state != IDLE
done  out  1  one-cycle pulse after last output handshake
pi_err  out  1  sticky: a ROM entry >= blk_len was seen this block

Behaviour:
- Reset (n_rst=0 at clk edge): state=IDLE; counters, FIFO pointers, in-flight pipe cleared; s_ready=0, m_valid=0, m_last=0, busy=0, done=0, pi_err=0, rom_addr=0. Buffer RAM contents not cleared. Reset mid-block aborts it; no done.
- States: IDLE, LOAD, PERM, DRAIN.
- IDLE: start=1 and blk_len!=0 -> latch base/len, clear pi_err, LOAD. start with blk_len=0 ignored. start outside IDLE ignored.
- LOAD: s_ready=1; each s_valid&s_ready writes buf[wr_cnt], wr_cnt++. Write of index blk_len-1 -> PERM, wr_cnt=0.
- PERM: rd_cnt 0..blk_len-1. Issue condition: fifo_count + inflight < FIFO_DEPTH. On issue rom_addr=(base+rd_cnt) mod 2^A_WIDTH, rd_cnt++. Stage 1 (+1 cycle): rom_data drives buffer read address. Stage 2 (+2): buffer data pushed to FIFO with last flag = (index == blk_len-1). Issue of index blk_len-1 -> DRAIN.
- Timing: first PERM cycle T issues index 0; m_valid first high at T+3. With m_ready held 1, one sample per cycle, no bubbles.
- inflight counts issued-not-yet-pushed entries (0..2); the credit rule guarantees no FIFO overflow under any m_ready pattern.
- Output: m_valid = FIFO non-empty; m_data/m_last from FIFO head; pop on m_valid&m_ready. m_data/m_last held stable while m_valid&!m_ready.
- DRAIN: no issues; when pop of m_last entry occurs -> done=1 next cycle, state IDLE. busy drops the same cycle done rises.
- pi_err: set at stage 1 when rom_data >= blk_len; sample still emitted (data undefined); cleared only on new start or reset.
- Simultaneous push and pop on same cycle: count unchanged, both performed.
- rom_addr holds last value when not issuing.

Decomposition:
- Shared turbo_pkg: PI_WIDTH, A_WIDTH, state encoding, link-id base/length constants table (for bench and top-level link select).
- One sub-module: turbo_buf_ram, simple dual-port synchronous RAM, 2^PI_WIDTH x D_WIDTH, 1-cycle read latency, write port from LOAD, read port from stage 1.

Test Plan:
- Base 952, len 288, ROM pi[k]=287-k, input 0..287 -> output 287,286,...,0; m_last on 0; done 1 cycle after; m_valid at T+3.
- Base 0, len 952, ROM identity, m_ready random 50% -> output 0..951 in order, no loss/duplication, data stable while stalled.
- len=1, base 65535 -> one sample out with m_last=1, done; len=0 start -> stays IDLE, busy=0.
- start pulse during LOAD and PERM -> ignored, latched len/base unchanged, block completes normally.
- n_rst=0 mid-PERM after 100 outputs -> next cycle all outputs at reset values; new start with len 192 completes correctly.
- ROM entry 300 at k=5 with len 288 -> pi_err=1 from that sample, stays 1 to done, cleared on next start.

Source files
------------

// File: rtl/turbo_pkg.sv
// Shared definitions for the turbo interleaver path.
// Holds the default widths, the FSM state encoding and the table of
// per-link permutation segments (ROM base and block length per link id).
package turbo_pkg;

  localparam int D_WIDTH    = 8;
  localparam int PI_WIDTH   = 13;
  localparam int A_WIDTH    = 16;
  localparam int FIFO_DEPTH = 4;

  localparam int NUM_LINKS  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_PERM  = 2'd2,
    ST_DRAIN = 2'd3
  } pi_state_t;

  // ROM offset of each link's permutation table
  function automatic logic [A_WIDTH-1:0] link_base(input int unsigned id);
    case (id)
      0:       link_base = 16'd0;
      1:       link_base = 16'd952;
      2:       link_base = 16'd1240;
      default: link_base = 16'd65535;
    endcase
  endfunction

  // Block length served by each link
  function automatic logic [PI_WIDTH-1:0] link_len(input int unsigned id);
    case (id)
      0:       link_len = 13'd952;
      1:       link_len = 13'd288;
      2:       link_len = 13'd192;
      default: link_len = 13'd1;
    endcase
  endfunction

endpackage

// File: rtl/turbo_buf_ram.sv
// Block buffer for the interleaver: simple dual-port synchronous RAM,
// 2^AW words of DW bits, registered read (data one cycle after raddr).
// Ports:
//   clk            clock
//   we/waddr/wdata write port (natural-order load)
//   raddr/rdata    read port (permuted read, 1-cycle latency)
// Contents are not reset.
module turbo_buf_ram #(
  parameter int AW = 13,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/turbo_pi_interleaver.sv
// Turbo interleaver stage: buffers one block in natural order, then walks
// the permutation ROM segment base..base+len-1 and streams out[k] = in[pi[k]].
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start with nonzero blk_len
// LOAD  | accepting blk_len input samples into the buffer
// PERM  | issuing ROM reads k = 0..len-1 under FIFO credit
// DRAIN | all reads issued; waiting for the m_last pop
//
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   start/base_addr/blk_len  block command, latched in IDLE
//   s_valid/s_data/s_ready   natural-order input stream
//   m_valid/m_data/m_last/m_ready  permuted output stream
//   rom_addr/rom_data     permutation ROM port (registered ROM)
//   busy, done, pi_err    status
module turbo_pi_interleaver #(
  parameter int D_WIDTH    = turbo_pkg::D_WIDTH,
  parameter int PI_WIDTH   = turbo_pkg::PI_WIDTH,
  parameter int A_WIDTH    = turbo_pkg::A_WIDTH,
  parameter int FIFO_DEPTH = turbo_pkg::FIFO_DEPTH
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [A_WIDTH-1:0]  base_addr,
  input  logic [PI_WIDTH-1:0] blk_len,
  input  logic                s_valid,
  input  logic [D_WIDTH-1:0]  s_data,
  output logic                s_ready,
  output logic                m_valid,
  output logic [D_WIDTH-1:0]  m_data,
  output logic                m_last,
  input  logic                m_ready,
  output logic [A_WIDTH-1:0]  rom_addr,
  input  logic [PI_WIDTH-1:0] rom_data,
  output logic                busy,
  output logic                done,
  output logic                pi_err
);

  import turbo_pkg::*;

  localparam int PW = $clog2(FIFO_DEPTH);

  pi_state_t state, state_nxt;

  logic [A_WIDTH-1:0]  base_q, rom_addr_q;
  logic [PI_WIDTH-1:0] len_q, len_m1, wr_cnt, rd_cnt;
  logic                s1_vld, s1_last, s2_vld, s2_last;
  logic                pi_err_q, done_q;

  logic [D_WIDTH-1:0]    fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           fifo_cnt, inflight, occ;

  logic                wr_en, issue, push, pop, start_ok, idx_last;
  logic [D_WIDTH-1:0]  ram_rdata;

  assign len_m1   = len_q - PI_WIDTH'(1);
  assign start_ok = start && (blk_len != '0);
  assign idx_last = (rd_cnt == len_m1);

  // Entries issued but not yet in the FIFO are exactly the two pipe stages.
  assign inflight = (PW+1)'(s1_vld) + (PW+1)'(s2_vld);
  assign occ      = fifo_cnt + inflight;

  assign push    = s2_vld;
  assign pop     = m_valid && m_ready;
  assign m_valid = (fifo_cnt != '0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];

  assign s_ready = (state == ST_LOAD);
  assign busy    = (state != ST_IDLE);
  assign done    = done_q;
  assign pi_err  = pi_err_q;

  // Combinational on issue so the registered ROM returns data at stage 1;
  // otherwise holds the last issued address.
  assign rom_addr = issue ? (base_q + A_WIDTH'(rd_cnt)) : rom_addr_q;

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    issue     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_ok) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        wr_en = s_valid;
        if (s_valid && (wr_cnt == len_m1)) state_nxt = ST_PERM;
      end
      ST_PERM: begin
        // Credit rule: a slot is reserved in the FIFO for every in-flight read.
        issue = (occ < (PW+1)'(FIFO_DEPTH));
        if (issue && idx_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && m_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state      <= ST_IDLE;
      base_q     <= '0;
      len_q      <= '0;
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      rom_addr_q <= '0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s2_vld     <= 1'b0;
      s2_last    <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_cnt   <= '0;
      pi_err_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;

      if (state == ST_IDLE && start_ok) begin
        base_q   <= base_addr;
        len_q    <= blk_len;
        pi_err_q <= 1'b0;
        wr_cnt   <= '0;
        rd_cnt   <= '0;
      end

      if (wr_en) wr_cnt <= (wr_cnt == len_m1) ? '0 : wr_cnt + PI_WIDTH'(1);

      if (issue) begin
        rom_addr_q <= rom_addr;
        rd_cnt     <= idx_last ? '0 : rd_cnt + PI_WIDTH'(1);
      end

      s1_vld  <= issue;
      s1_last <= issue && idx_last;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;

      if (s1_vld && (rom_data >= len_q)) pi_err_q <= 1'b1;

      if (state == ST_DRAIN && pop && m_last) done_q <= 1'b1;

      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // FIFO storage carries no reset; validity comes from fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= ram_rdata;
      fifo_last[wr_ptr] <= s2_last;
    end
  end

  turbo_buf_ram #(
    .AW(PI_WIDTH),
    .DW(D_WIDTH)
  ) u_buf (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_cnt),
    .wdata(s_data),
    .raddr(rom_data),
    .rdata(ram_rdata)
  );

endmodule

// File: tb/tb_turbo_pi_interleaver.sv
module tb_turbo_pi_interleaver;
  import turbo_pkg::*;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [15:0] base_addr;
  logic [12:0] blk_len;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_ready;
  logic        m_valid;
  logic [7:0]  m_data;
  logic        m_last;
  logic        m_ready;
  logic [15:0] rom_addr;
  logic [12:0] rom_data;
  logic        busy;
  logic        done;
  logic        pi_err;

  int n_checks = 0;
  int n_errs   = 0;

  logic [12:0] rom    [65536];
  logic [7:0]  blk_in [8192];

  turbo_pi_interleaver dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .base_addr(base_addr),
    .blk_len  (blk_len),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .m_valid  (m_valid),
    .m_data   (m_data),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .busy     (busy),
    .done     (done),
    .pi_err   (pi_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered permutation ROM
  always @(posedge clk) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_s_ready"},  s_ready,  0);
    chk({tag, "_m_valid"},  m_valid,  0);
    chk({tag, "_m_last"},   m_last,   0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_pi_err"},   pi_err,   0);
    chk({tag, "_rom_addr"}, rom_addr, 0);
  endtask

  // One block: expected stream is in[pi[k]] with pi read from the ROM model.
  task automatic run_block(input int base, input int len, input int rdy_pct,
                           input int vld_pct, input bit ramp, input bit inject,
                           input int abort_at);
    int n, in_cnt, out_cnt, n_last_in, n_first_out, n_last_out, idx;
    bit held, finished, any_bad;
    logic [7:0] held_data;
    logic held_last;
    any_bad = 1'b0;
    for (int k = 0; k < len; k++) begin
      blk_in[k] = ramp ? 8'(k) : 8'($urandom);
      if (int'(rom[(base + k) % 65536]) >= len) any_bad = 1'b1;
    end
    @(negedge clk);
    base_addr = 16'(base);
    blk_len   = 13'(len);
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("pi_err_cleared", pi_err, 0);
    n = 0; in_cnt = 0; out_cnt = 0; n_last_in = -10; n_first_out = -1;
    n_last_out = 0; held = 1'b0; finished = 1'b0;
    held_data = '0; held_last = 1'b0;
    while (!finished && n < 20000) begin
      if (held) begin
        chk("m_valid_hold", m_valid, 1);
        chk("m_data_hold", m_data, held_data);
        chk("m_last_hold", m_last, held_last);
      end
      if (n == n_last_in + 1) chk("rom_addr_first", rom_addr, base % 65536);
      if (m_valid && n_first_out < 0) begin
        n_first_out = n;
        chk("first_out_latency", n - n_last_in, 4);
        chk("pi_err_first_out", pi_err, 0);
      end
      if (abort_at > 0 && out_cnt == abort_at) begin
        n_rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
        @(negedge clk);
        chk_reset_outputs("abort");
        n_rst = 1'b1;
        return;
      end
      start = inject && ((in_cnt == len / 2 && s_ready) ||
                         (out_cnt == len / 2 && m_valid));
      if (start) begin
        base_addr = 16'($urandom);
        blk_len   = 13'($urandom_range(1, 50));
      end
      s_valid = ($urandom_range(0, 99) < vld_pct);
      s_data  = (in_cnt < len) ? blk_in[in_cnt] : 8'($urandom);
      if (s_ready && s_valid) begin
        in_cnt++;
        if (in_cnt == len) n_last_in = n;
      end
      m_ready = ($urandom_range(0, 99) < rdy_pct);
      held = 1'b0;
      if (m_valid && m_ready) begin
        idx = int'(rom[(base + out_cnt) % 65536]);
        if (idx < len) chk("m_data", m_data, blk_in[idx]);
        else           chk("pi_err_bad_entry", pi_err, 1);
        chk("m_last", m_last, (out_cnt == len - 1));
        out_cnt++;
        if (out_cnt == len) begin
          n_last_out = n;
          finished   = 1'b1;
        end
      end else if (m_valid) begin
        held = 1'b1; held_data = m_data; held_last = m_last;
      end
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0; m_ready = 1'b0; start = 1'b0;
    chk("block_complete", out_cnt, len);
    chk("done_pulse", done, 1);
    chk("busy_low_with_done", busy, 0);
    if (rdy_pct == 100) chk("no_bubbles", n_last_out - n_first_out, len - 1);
    chk("pi_err_end", pi_err, any_bad);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    int p[192];
    int j, t;
    n_rst = 1'b0; start = 1'b0; base_addr = '0; blk_len = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    for (int i = 0; i < 65536; i++) rom[i] = '0;
    for (int k = 0; k < 952; k++) rom[k] = 13'(k);
    for (int k = 0; k < 288; k++) rom[952 + k] = 13'(287 - k);
    for (int i = 0; i < 192; i++) p[i] = i;
    for (int i = 191; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    for (int i = 0; i < 192; i++) rom[1240 + i] = 13'(p[i]);
    rom[65535] = 13'd0;

    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    n_rst = 1'b1;
    @(negedge clk);

    // Reversed table, counting input, full-rate output
    run_block(int'(link_base(1)), int'(link_len(1)), 100, 100, 1'b1, 1'b0, 0);
    // Identity table, random stalls on both sides
    run_block(int'(link_base(0)), int'(link_len(0)), 50, 70, 1'b0, 1'b0, 0);
    // Single-sample block at the top of the ROM
    run_block(int'(link_base(3)), int'(link_len(3)), 100, 100, 1'b0, 1'b0, 0);

    // Zero-length start is ignored
    @(negedge clk);
    blk_len = '0; base_addr = 16'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("len0_busy", busy, 0);
      chk("len0_s_ready", s_ready, 0);
      @(negedge clk);
    end

    // Stray start pulses during LOAD and PERM
    run_block(int'(link_base(2)), int'(link_len(2)), 70, 80, 1'b0, 1'b1, 0);
    // Reset after 100 outputs, then a clean block
    run_block(int'(link_base(1)), int'(link_len(1)), 60, 100, 1'b0, 1'b0, 100);
    run_block(int'(link_base(2)), int'(link_len(2)), 100, 100, 1'b0, 1'b0, 0);
    // Out-of-range ROM entry at k=5, then clean rerun clears pi_err
    rom[952 + 5] = 13'd300;
    run_block(int'(link_base(1)), int'(link_len(1)), 80, 100, 1'b0, 1'b0, 0);
    rom[952 + 5] = 13'(287 - 5);
    run_block(int'(link_base(1)), int'(link_len(1)), 100, 100, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
